// File: rtl/uart_fifo_if.sv
// CPU-side byte strobes, status flags and the serial pins of uart_fifo.
interface uart_fifo_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic                 tx_wr;
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_full;
    logic                 tx_idle;
    logic                 tx_out;
    logic                 rx_in;
    logic                 rx_rd;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_empty;
    logic                 rx_frame_err;
    logic                 rx_over_run;
    logic                 tx_over_run;
    logic                 rx_parity_err;
    logic                 err_clr;

    modport master (
        output tx_wr, tx_data, rx_in, rx_rd, err_clr,
        input  tx_full, tx_idle, tx_out, rx_data, rx_empty,
               rx_frame_err, rx_over_run, tx_over_run, rx_parity_err
    );

    modport slave (
        input  tx_wr, tx_data, rx_in, rx_rd, err_clr,
        output tx_full, tx_idle, tx_out, rx_data, rx_empty,
               rx_frame_err, rx_over_run, tx_over_run, rx_parity_err
    );
endinterface

// File: rtl/uart_fifo.sv
// Single-clock UART with shared baud tick, 16x-style oversampled RX and TX/RX FIFOs.
// Optional parity bit enabled by defining UART_PARITY_EN (PARITY_ODD selects odd).
module uart_fifo #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned CLK_DIV    = 27,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned PARITY_ODD = 0
) (
    input logic       clk,
    input logic       reset,
    uart_fifo_if.slave bus
);
    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned OS_W  = $clog2(OVERSAMPLE);
    localparam int unsigned BIT_W = $clog2(DATA_BITS);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
`ifdef UART_PARITY_EN
        TX_PARITY,
`endif
        TX_STOP
    } tx_state_e;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
`ifdef UART_PARITY_EN
        RX_PARITY,
`endif
        RX_STOP,
        RX_WAIT
    } rx_state_e;

    // Free-running baud tick
    logic [DIV_W-1:0] div_q;
    logic             tick;
    assign tick = (div_q == DIV_W'(CLK_DIV - 1));

    always_ff @(posedge clk) begin
        if (reset) div_q <= '0;
        else       div_q <= tick ? '0 : div_q + DIV_W'(1);
    end

    // TX FIFO
    logic [DATA_BITS-1:0] tx_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     tx_wp_q, tx_rp_q;
    logic [CNT_W-1:0]     tx_cnt_q, tx_cnt_d;
    logic                 tx_full_q, tx_push, tx_pop, tx_os_last;
    logic [DATA_BITS-1:0] tx_head;

    tx_state_e            tx_st_q;
    logic [OS_W-1:0]      tx_os_q;
    logic [BIT_W-1:0]     tx_bit_q;
    logic [DATA_BITS-1:0] tx_shift_q;
    logic                 tx_out_q, tx_idle_q;

    assign tx_push    = bus.tx_wr && !tx_full_q;
    assign tx_os_last = (tx_os_q == OS_W'(OVERSAMPLE - 1));
    assign tx_pop     = tick && (tx_cnt_q != '0) &&
                        ((tx_st_q == TX_IDLE) || ((tx_st_q == TX_STOP) && tx_os_last));
    assign tx_cnt_d   = tx_cnt_q + CNT_W'(tx_push) - CNT_W'(tx_pop);
    assign tx_head    = tx_mem[tx_rp_q];

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wp_q] <= bus.tx_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_wp_q   <= '0;
            tx_rp_q   <= '0;
            tx_cnt_q  <= '0;
            tx_full_q <= 1'b0;
        end else begin
            tx_wp_q   <= tx_wp_q + PTR_W'(tx_push);
            tx_rp_q   <= tx_rp_q + PTR_W'(tx_pop);
            tx_cnt_q  <= tx_cnt_d;
            tx_full_q <= (tx_cnt_d == CNT_W'(FIFO_DEPTH));
        end
    end

`ifdef UART_PARITY_EN
    logic tx_par_q;
`endif

    // TX frame sequencer; a pop at the end of STOP chains the next frame without a gap
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_st_q    <= TX_IDLE;
            tx_os_q    <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_out_q   <= 1'b1;
            tx_idle_q  <= 1'b1;
`ifdef UART_PARITY_EN
            tx_par_q   <= 1'b0;
`endif
        end else begin
            tx_idle_q <= (tx_cnt_d == '0) && !tx_pop &&
                         ((tx_st_q == TX_IDLE) || ((tx_st_q == TX_STOP) && tick && tx_os_last));
            if (tick) begin
                tx_os_q <= tx_os_last ? '0 : tx_os_q + OS_W'(1);
                if (tx_pop) begin
                    tx_shift_q <= tx_head;
`ifdef UART_PARITY_EN
                    tx_par_q   <= (^tx_head) ^ 1'(PARITY_ODD);
`endif
                    tx_out_q   <= 1'b0;
                    tx_os_q    <= '0;
                    tx_st_q    <= TX_START;
                end else begin
                    case (tx_st_q)
                        TX_IDLE: tx_os_q <= '0;
                        TX_START: if (tx_os_last) begin
                            tx_bit_q <= '0;
                            tx_out_q <= tx_shift_q[0];
                            tx_st_q  <= TX_DATA;
                        end
                        TX_DATA: if (tx_os_last) begin
                            tx_shift_q <= tx_shift_q >> 1;
                            if (tx_bit_q == BIT_W'(DATA_BITS - 1)) begin
`ifdef UART_PARITY_EN
                                tx_out_q <= tx_par_q;
                                tx_st_q  <= TX_PARITY;
`else
                                tx_out_q <= 1'b1;
                                tx_st_q  <= TX_STOP;
`endif
                            end else begin
                                tx_bit_q <= tx_bit_q + BIT_W'(1);
                                tx_out_q <= tx_shift_q[1];
                            end
                        end
`ifdef UART_PARITY_EN
                        TX_PARITY: if (tx_os_last) begin
                            tx_out_q <= 1'b1;
                            tx_st_q  <= TX_STOP;
                        end
`endif
                        TX_STOP: if (tx_os_last) tx_st_q <= TX_IDLE;
                        default: tx_st_q <= TX_IDLE;
                    endcase
                end
            end
        end
    end

    // RX synchroniser and sequencer
    logic [1:0]           rx_sync_q;
    logic                 rx_s;
    rx_state_e            rx_st_q;
    logic [OS_W-1:0]      rx_os_q;
    logic [BIT_W-1:0]     rx_bit_q;
    logic [DATA_BITS-1:0] rx_shift_q;
    logic                 rx_push_q, rx_os_last, rx_os_half;

    assign rx_s       = rx_sync_q[1];
    assign rx_os_last = (rx_os_q == OS_W'(OVERSAMPLE - 1));
    assign rx_os_half = (rx_os_q == OS_W'(OVERSAMPLE / 2 - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_sync_q  <= 2'b11;
            rx_st_q    <= RX_IDLE;
            rx_os_q    <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_push_q  <= 1'b0;
        end else begin
            rx_sync_q <= {rx_sync_q[0], bus.rx_in};
            rx_push_q <= 1'b0;
            if (rx_st_q == RX_WAIT) begin
                if (rx_s) rx_st_q <= RX_IDLE;
            end else if (tick) begin
                rx_os_q <= rx_os_last ? '0 : rx_os_q + OS_W'(1);
                case (rx_st_q)
                    RX_IDLE: begin
                        rx_os_q <= '0;
                        if (!rx_s) rx_st_q <= RX_START;
                    end
                    RX_START: if (rx_os_half) begin
                        rx_os_q  <= '0;
                        rx_bit_q <= '0;
                        rx_st_q  <= rx_s ? RX_IDLE : RX_DATA;
                    end
                    RX_DATA: if (rx_os_last) begin
                        rx_shift_q <= {rx_s, rx_shift_q[DATA_BITS-1:1]};
                        if (rx_bit_q == BIT_W'(DATA_BITS - 1)) begin
`ifdef UART_PARITY_EN
                            rx_st_q <= RX_PARITY;
`else
                            rx_st_q <= RX_STOP;
`endif
                        end else begin
                            rx_bit_q <= rx_bit_q + BIT_W'(1);
                        end
                    end
`ifdef UART_PARITY_EN
                    RX_PARITY: if (rx_os_last) rx_st_q <= RX_STOP;
`endif
                    RX_STOP: if (rx_os_last) begin
                        rx_push_q <= rx_s;
                        rx_st_q   <= rx_s ? RX_IDLE : RX_WAIT;
                    end
                    default: rx_st_q <= RX_IDLE;
                endcase
            end
        end
    end

    // RX FIFO with registered show-ahead head
    logic [DATA_BITS-1:0] rx_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     rx_wp_q, rx_rp_q, rx_rd_next;
    logic [CNT_W-1:0]     rx_cnt_q, rx_cnt_d;
    logic                 rx_empty_q, rx_full, rx_push, rx_pop;
    logic [DATA_BITS-1:0] rx_data_q, rx_head_d;

    assign rx_full    = (rx_cnt_q == CNT_W'(FIFO_DEPTH));
    assign rx_pop     = bus.rx_rd && !rx_empty_q;
    assign rx_push    = rx_push_q && (!rx_full || rx_pop);
    assign rx_cnt_d   = rx_cnt_q + CNT_W'(rx_push) - CNT_W'(rx_pop);
    assign rx_rd_next = rx_rp_q + PTR_W'(rx_pop);
    assign rx_head_d  = (rx_push && (rx_wp_q == rx_rd_next)) ? rx_shift_q : rx_mem[rx_rd_next];

    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wp_q] <= rx_shift_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_wp_q    <= '0;
            rx_rp_q    <= '0;
            rx_cnt_q   <= '0;
            rx_empty_q <= 1'b1;
            rx_data_q  <= '0;
        end else begin
            rx_wp_q    <= rx_wp_q + PTR_W'(rx_push);
            rx_rp_q    <= rx_rd_next;
            rx_cnt_q   <= rx_cnt_d;
            rx_empty_q <= (rx_cnt_d == '0);
            rx_data_q  <= (rx_cnt_d == '0) ? '0 : rx_head_d;
        end
    end

    // Sticky error flags; a same-cycle event overrides err_clr
    logic rx_frame_err_q, rx_over_run_q, tx_over_run_q;
    logic rx_frame_ev, rx_ovr_ev, tx_ovr_ev;

    assign rx_frame_ev = tick && (rx_st_q == RX_STOP) && rx_os_last && !rx_s;
    assign rx_ovr_ev   = rx_push_q && rx_full && !rx_pop;
    assign tx_ovr_ev   = bus.tx_wr && tx_full_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_frame_err_q <= 1'b0;
            rx_over_run_q  <= 1'b0;
            tx_over_run_q  <= 1'b0;
        end else begin
            if (bus.err_clr) begin
                rx_frame_err_q <= 1'b0;
                rx_over_run_q  <= 1'b0;
                tx_over_run_q  <= 1'b0;
            end
            if (rx_frame_ev) rx_frame_err_q <= 1'b1;
            if (rx_ovr_ev)   rx_over_run_q  <= 1'b1;
            if (tx_ovr_ev)   tx_over_run_q  <= 1'b1;
        end
    end

`ifdef UART_PARITY_EN
    logic rx_parity_err_q, rx_par_ev;
    assign rx_par_ev = tick && (rx_st_q == RX_PARITY) && rx_os_last &&
                       (rx_s != ((^rx_shift_q) ^ 1'(PARITY_ODD)));

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_parity_err_q <= 1'b0;
        end else begin
            if (bus.err_clr) rx_parity_err_q <= 1'b0;
            if (rx_par_ev)   rx_parity_err_q <= 1'b1;
        end
    end
    assign bus.rx_parity_err = rx_parity_err_q;
`else
    assign bus.rx_parity_err = 1'b0 & 1'(PARITY_ODD);
`endif

    assign bus.tx_full      = tx_full_q;
    assign bus.tx_idle      = tx_idle_q;
    assign bus.tx_out       = tx_out_q;
    assign bus.rx_data      = rx_data_q;
    assign bus.rx_empty     = rx_empty_q;
    assign bus.rx_frame_err = rx_frame_err_q;
    assign bus.rx_over_run  = rx_over_run_q;
    assign bus.tx_over_run  = tx_over_run_q;
endmodule

// File: tb/tb_uart_fifo.sv
// Directed bench for uart_fifo at CLK_DIV=4, OVERSAMPLE=16 (64 clk per bit).
module tb_uart_fifo;
    localparam int unsigned BIT_CLKS = 64;

    logic clk = 1'b0;
    logic reset;
    logic loop;
    logic rx_drv;
    int   checks = 0;
    int   errors = 0;

    uart_fifo_if #(.DATA_BITS(8)) bus ();
    assign bus.rx_in = loop ? bus.tx_out : rx_drv;

    uart_fifo #(
        .DATA_BITS (8),
        .CLK_DIV   (4),
        .OVERSAMPLE(16),
        .FIFO_DEPTH(16),
        .PARITY_ODD(0)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        rx_drv = b;
        repeat (BIT_CLKS) step();
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic flip);
        logic par;
        par = (^d) ^ flip;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_PARITY_EN
        drive_bit(par);
`endif
        drive_bit(stop_bit);
    endtask

    task automatic pop();
        bus.rx_rd = 1'b1;
        step();
        bus.rx_rd = 1'b0;
    endtask

    task automatic check_flags(input string tag);
        check({tag, "_frame"}, 32'(bus.rx_frame_err), 0);
        check({tag, "_rxovr"}, 32'(bus.rx_over_run), 0);
        check({tag, "_txovr"}, 32'(bus.tx_over_run), 0);
        check({tag, "_par"},   32'(bus.rx_parity_err), 0);
    endtask

    initial begin
        reset       = 1'b1;
        loop        = 1'b0;
        rx_drv      = 1'b1;
        bus.tx_wr   = 1'b0;
        bus.tx_data = '0;
        bus.rx_rd   = 1'b0;
        bus.err_clr = 1'b0;
        repeat (3) step();
        check("rst_tx_out",   32'(bus.tx_out), 1);
        check("rst_tx_full",  32'(bus.tx_full), 0);
        check("rst_tx_idle",  32'(bus.tx_idle), 1);
        check("rst_rx_empty", 32'(bus.rx_empty), 1);
        check("rst_rx_data",  32'(bus.rx_data), 0);
        check_flags("rst");
        reset = 1'b0;
        step();

        // Loopback of two back-to-back bytes
        loop        = 1'b1;
        bus.tx_wr   = 1'b1;
        bus.tx_data = 8'h55;
        step();
        bus.tx_data = 8'hA3;
        step();
        bus.tx_wr = 1'b0;
        for (int n = 0; n < 3000 && bus.rx_empty; n++) step();
        check("lb_first_arrive", 32'(bus.rx_empty), 0);
        check("lb_first_data",   32'(bus.rx_data), 32'h55);
        pop();
        check("lb_empty_after_pop", 32'(bus.rx_empty), 1);
        for (int n = 0; n < 3000 && bus.rx_empty; n++) step();
        check("lb_second_arrive", 32'(bus.rx_empty), 0);
        check("lb_second_data",   32'(bus.rx_data), 32'hA3);
        pop();
        for (int n = 0; n < 1000 && !bus.tx_idle; n++) step();
        check("lb_tx_idle",  32'(bus.tx_idle), 1);
        check("lb_rx_empty", 32'(bus.rx_empty), 1);
        check_flags("lb");
        loop = 1'b0;

        // Fill TX FIFO while the shifter is busy with a frame of zeros
        bus.tx_wr   = 1'b1;
        bus.tx_data = 8'h00;
        step();
        bus.tx_wr = 1'b0;
        for (int n = 0; n < 50 && bus.tx_out; n++) step();
        check("txf_start_bit", 32'(bus.tx_out), 0);
        for (int i = 0; i < 17; i++) begin
            bus.tx_wr   = 1'b1;
            bus.tx_data = 8'(i + 1);
            step();
            if (i == 14) check("txf_not_full_15", 32'(bus.tx_full), 0);
            if (i == 15) check("txf_full_16",     32'(bus.tx_full), 1);
        end
        bus.tx_wr = 1'b0;
        check("txf_overrun", 32'(bus.tx_over_run), 1);
        bus.err_clr = 1'b1;
        step();
        bus.err_clr = 1'b0;
        check("txf_overrun_clr", 32'(bus.tx_over_run), 0);

        // Reset in the middle of a TX frame
        check("rstmid_pre_low", 32'(bus.tx_out), 0);
        reset = 1'b1;
        step();
        check("rstmid_tx_out",  32'(bus.tx_out), 1);
        check("rstmid_tx_full", 32'(bus.tx_full), 0);
        check("rstmid_tx_idle", 32'(bus.tx_idle), 1);
        reset = 1'b0;
        repeat (300) step();
        check("rstmid_stays_high", 32'(bus.tx_out), 1);
        check("rstmid_still_idle", 32'(bus.tx_idle), 1);

        // Bad stop bit, then a good frame
        send_frame(8'h3C, 1'b0, 1'b0);
        rx_drv = 1'b1;
        repeat (70) step();
        check("fe_flag",     32'(bus.rx_frame_err), 1);
        check("fe_no_store", 32'(bus.rx_empty), 1);
        send_frame(8'h01, 1'b1, 1'b0);
        repeat (6) step();
        check("fe_next_arrive", 32'(bus.rx_empty), 0);
        check("fe_next_data",   32'(bus.rx_data), 32'h01);
        pop();
        bus.err_clr = 1'b1;
        step();
        bus.err_clr = 1'b0;
        check("fe_clr", 32'(bus.rx_frame_err), 0);

        // 17 frames with no reads: 16 kept, last dropped
        for (int i = 0; i < 17; i++) send_frame((i < 16) ? 8'(i * 8'h11) : 8'h5A, 1'b1, 1'b0);
        repeat (6) step();
        check("ovr_flag", 32'(bus.rx_over_run), 1);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("ovr_pop%0d", i), 32'(bus.rx_data), 32'(i * 8'h11));
            pop();
        end
        check("ovr_drained", 32'(bus.rx_empty), 1);
        check("ovr_data0",   32'(bus.rx_data), 0);
        pop();
        check("ovr_pop_empty_ignored", 32'(bus.rx_empty), 1);
        bus.err_clr = 1'b1;
        step();
        bus.err_clr = 1'b0;

        // Short low glitch is rejected
        rx_drv = 1'b0;
        repeat (12) step();
        rx_drv = 1'b1;
        repeat (200) step();
        check("gl_no_char", 32'(bus.rx_empty), 1);
        check_flags("gl");

`ifdef UART_PARITY_EN
        // Parity bit on the wire for 0x07 (three ones, even parity -> 1)
        bus.tx_wr   = 1'b1;
        bus.tx_data = 8'h07;
        step();
        bus.tx_wr = 1'b0;
        for (int n = 0; n < 50 && bus.tx_out; n++) step();
        check("par_tx_start", 32'(bus.tx_out), 0);
        repeat (BIT_CLKS + BIT_CLKS / 2) step();
        check("par_tx_bit0", 32'(bus.tx_out), 1);
        repeat (BIT_CLKS * 8) step();
        check("par_tx_parity", 32'(bus.tx_out), 1);
        repeat (BIT_CLKS) step();
        check("par_tx_stop", 32'(bus.tx_out), 1);
        send_frame(8'h07, 1'b1, 1'b0);
        repeat (6) step();
        check("par_rx_ok_flag", 32'(bus.rx_parity_err), 0);
        check("par_rx_ok_data", 32'(bus.rx_data), 32'h07);
        pop();
        send_frame(8'h07, 1'b1, 1'b1);
        repeat (6) step();
        check("par_rx_bad_flag",  32'(bus.rx_parity_err), 1);
        check("par_rx_bad_data",  32'(bus.rx_data), 32'h07);
        check("par_rx_bad_store", 32'(bus.rx_empty), 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
